// File: rtl/rx_block_packer.sv
// rtl/rx_block_packer.sv - packs UART bytes into 128-bit blocks; `RX_TIMEOUT_EN adds an inter-byte idle discard
module rx_block_packer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         blk_valid,
    output logic [127:0] blk_data,
    input  logic         blk_ready,
    output logic [3:0]   byte_cnt,
    output logic         overflow,
    input  logic         ovf_clr,
    output logic         timeout
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   blk_data_q, blk_data_d;
    logic [3:0]     byte_cnt_q, byte_cnt_d;
    logic           overflow_q, overflow_d;
    logic [6:0]     wr_lsb;

`ifdef RX_TIMEOUT_EN
    logic [31:0]    idle_cnt_q, idle_cnt_d;
    logic           timeout_q, timeout_d;
`endif

    // Slot 0 sits in the top byte so the first received byte is the block MSB.
    assign wr_lsb = {4'd15 - byte_cnt_q, 3'b000};

    always_comb begin
        state_d    = state_q;
        blk_data_d = blk_data_q;
        byte_cnt_d = byte_cnt_q;
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (state_q == COLLECT) begin
            if (rx_valid) begin
                blk_data_d[wr_lsb +: 8] = rx_data;
                byte_cnt_d = byte_cnt_q + 4'd1;
                if (byte_cnt_q == 4'd15) begin
                    state_d = FULL;
                end
            end
        end else begin
            if (blk_ready) begin
                state_d = COLLECT;
                if (rx_valid) begin
                    blk_data_d[127:120] = rx_data;
                    byte_cnt_d = 4'd1;
                end else begin
                    byte_cnt_d = 4'd0;
                end
            end else if (rx_valid) begin
                overflow_d = 1'b1;
            end
        end
`ifdef RX_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
        timeout_d  = 1'b0;
        // Only a byte-less cycle in a partial block can expire, so a byte always wins.
        if (rx_valid) begin
            idle_cnt_d = 32'd0;
        end else if (state_q == COLLECT && byte_cnt_q != 4'd0) begin
            if (idle_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                idle_cnt_d = 32'd0;
                byte_cnt_d = 4'd0;
                timeout_d  = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= COLLECT;
            blk_data_q <= 128'd0;
            byte_cnt_q <= 4'd0;
            overflow_q <= 1'b0;
`ifdef RX_TIMEOUT_EN
            idle_cnt_q <= 32'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            blk_data_q <= blk_data_d;
            byte_cnt_q <= byte_cnt_d;
            overflow_q <= overflow_d;
`ifdef RX_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign blk_valid = (state_q == FULL);
    assign blk_data  = blk_data_q;
    assign byte_cnt  = byte_cnt_q;
    assign overflow  = overflow_q;
`ifdef RX_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rx_block_packer.sv
// tb/tb_rx_block_packer.sv - scoreboard bench for rx_block_packer with a queue-based byte/block model
module tb_rx_block_packer;

    localparam int TO = 50;

    logic         clk = 1'b0;
    logic         rstn;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic [3:0]   byte_cnt;
    logic         overflow;
    logic         ovf_clr;
    logic         timeout;

    rx_block_packer #(.TIMEOUT_CYCLES(32'(TO))) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_ready (blk_ready),
        .byte_cnt  (byte_cnt),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   part[$];
    bit           m_pend;
    bit           m_ovf;
    bit           m_to;
    int           m_idle;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted block is compared against the oldest expected block.
    always @(negedge clk) begin
        if (rstn === 1'b1 && blk_valid === 1'b1 && blk_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL blk_unexpected: got %h expected no block", blk_data);
            end else begin
                check("blk_data", blk_data, exp_q.pop_front());
            end
        end
    end

    function automatic void model_step(input bit v, input logic [7:0] d, input bit r, input bit c);
        bit drop = 1'b0;
        logic [127:0] blk;
        m_to = 1'b0;
        if (m_pend && r) m_pend = 1'b0;
        if (v) begin
            m_idle = 0;
            if (m_pend) begin
                drop = 1'b1;
            end else begin
                part.push_back(d);
                if (part.size() == 16) begin
                    for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = part[i];
                    exp_q.push_back(blk);
                    part.delete();
                    m_pend = 1'b1;
                end
            end
        end
`ifdef RX_TIMEOUT_EN
        else if (!m_pend && part.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                part.delete();
                m_idle = 0;
                m_to = 1'b1;
            end
        end
`endif
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endfunction

    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit c);
        rx_valid  = v;
        rx_data   = d;
        blk_ready = r;
        ovf_clr   = c;
        model_step(v, d, r, c);
        @(posedge clk);
        #1;
        check("byte_cnt", 128'(byte_cnt), 128'(part.size()));
        check("overflow", 128'(overflow), 128'(m_ovf));
        check("blk_valid", 128'(blk_valid), 128'(m_pend));
        check("timeout", 128'(timeout), 128'(m_to));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        blk_ready = 1'b0;
        ovf_clr = 1'b0;
        part.delete();
        exp_q.delete();
        m_pend = 1'b0;
        m_ovf = 1'b0;
        m_to = 1'b0;
        m_idle = 0;
        @(posedge clk);
        #1;
        check("rst_blk_valid", 128'(blk_valid), 128'd0);
        check("rst_blk_data", blk_data, 128'd0);
        check("rst_byte_cnt", 128'(byte_cnt), 128'd0);
        check("rst_overflow", 128'(overflow), 128'd0);
        check("rst_timeout", 128'(timeout), 128'd0);
        rstn = 1'b1;
    endtask

    task automatic send_seq(input logic [7:0] first, input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b1, first + 8'(i), r, 1'b0);
    endtask

    initial begin
        int to_pulses;
        do_reset();

        // 0x00..0x0F with the consumer always ready
        send_seq(8'h00, 16, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("seq0_overflow", 128'(overflow), 128'd0);

        // block held, extra byte dropped, then drained and overflow cleared
        send_seq(8'hA0, 16, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check("drop_blk_data", blk_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_byte_cnt", 128'(byte_cnt), 128'd0);
        check("drain_overflow", 128'(overflow), 128'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_overflow", 128'(overflow), 128'd0);

        // simultaneous byte and accept
        send_seq(8'h10, 16, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("simul_byte_cnt", 128'(byte_cnt), 128'd1);
        send_seq(8'h78, 15, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // reset mid-block discards the partial bytes
        send_seq(8'h30, 7, 1'b0);
        do_reset();
        send_seq(8'hC0, 16, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // idle after a 3-byte partial
        send_seq(8'hE0, 3, 1'b0);
        to_pulses = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (timeout === 1'b1) to_pulses++;
        end
`ifdef RX_TIMEOUT_EN
        check("to_pulses", 128'(to_pulses), 128'd1);
        check("to_byte_cnt", 128'(byte_cnt), 128'd0);
`else
        check("to_pulses", 128'(to_pulses), 128'd0);
        check("to_byte_cnt", 128'(byte_cnt), 128'd3);
`endif

        // randomized traffic with occasional long idle gaps
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int k = 0; k < 55; k++) step(1'b0, 8'h00, ($urandom_range(0, 3) == 0), 1'b0);
            end else begin
                step(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 9) < 3),
                     ($urandom_range(0, 19) == 0));
            end
        end
        for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("exp_q_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_block_packer.md
RX_BLOCK_PACKER -- requirements
Module: rx_block_packer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 32'd100000, inter-byte idle limit in clk cycles; used only when RX_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  system clock; all logic on posedge clk.
REQ-003 Port: rstn  input  1  reset, synchronous and active-low; sampled only on posedge clk.
REQ-004 Port: rx_valid  input  1  one-cycle byte strobe from the UART receiver.
REQ-005 Port: rx_data  input  8  received byte; qualified by rx_valid.
REQ-006 Port: blk_valid  output  1  128-bit block available.
REQ-007 Port: blk_data  output  128  assembled block.
REQ-008 Port: blk_ready  input  1  consumer (AES core) accepts the block.
REQ-009 Port: byte_cnt  output  4  bytes held in the partial block, 0..15.
REQ-010 Port: overflow  output  1  sticky; a byte was dropped.
REQ-011 Port: ovf_clr  input  1  clears overflow.
REQ-012 Port: timeout  output  1  one-cycle pulse; a partial block was discarded.

Function
REQ-013 The FSM SHALL have two states: COLLECT (blk_valid=0) and FULL (blk_valid=1).
REQ-014 In COLLECT, each rx_valid SHALL write rx_data into byte slot byte_cnt and increment byte_cnt.
REQ-015 Byte order: the first byte of a block SHALL land in blk_data[127:120] and the 16th in blk_data[7:0].
REQ-016 When the 16th byte is written, the FSM SHALL go to FULL on the same edge, with byte_cnt wrapping to 0; blk_valid asserts the cycle after the 16th rx_valid.
REQ-017 In FULL, blk_data and blk_valid SHALL hold stable until a cycle with blk_ready=1. The transfer SHALL occur on that edge, and the FSM SHALL return to COLLECT.
REQ-018 rx_valid in FULL without blk_ready SHALL drop the byte, leave blk_data unchanged and set overflow.
REQ-019 rx_valid and blk_ready in the same FULL cycle SHALL complete the transfer and store the byte as byte 0 of the next block (byte_cnt=1); overflow SHALL NOT be set.
REQ-020 blk_ready in COLLECT SHALL have no effect.
REQ-021 ovf_clr SHALL clear overflow on the next edge. A simultaneous drop SHALL take priority and leave overflow=1.
REQ-022 Unwritten slots of a partial block are don't-care. blk_data SHALL be fully defined whenever blk_valid=1.

Reset
REQ-023 With rstn=0 at a posedge, the block SHALL set state=COLLECT, blk_valid=0, blk_data=128'd0, byte_cnt=0, overflow=0, timeout=0 and the idle counter to 0.
REQ-024 Reset mid-block or in FULL SHALL discard all held bytes; the first rx_valid after reset becomes byte 0.

Configuration
REQ-025 Macro RX_TIMEOUT_EN, when defined, SHALL enable the inter-byte idle counter.
- The counter clears on every rx_valid and counts while in COLLECT with byte_cnt!=0.
- When it reaches TIMEOUT_CYCLES-1, the block SHALL reset byte_cnt to 0 and pulse timeout for 1 cycle.
- The counter SHALL NOT run in FULL.
- An rx_valid in the expiry cycle SHALL take priority: the byte is stored and there is no timeout.
REQ-026 Without RX_TIMEOUT_EN, the block SHALL keep the timeout port tied to 0 and partial blocks SHALL persist indefinitely.

Verification
REQ-027 Send 16 bytes 0x00..0x0F with blk_ready=1 -> blk_valid=1 for 1 cycle the cycle after the 16th byte; blk_data=128'h000102030405060708090A0B0C0D0E0F; overflow=0.
REQ-028 Send 16 bytes 0xA0..0xAF with blk_ready=0, then byte 0x55, then blk_ready=1 -> blk_data unchanged (A0..AF); overflow=1; next block starts empty (byte_cnt=0); ovf_clr -> overflow=0.
REQ-029 FULL with block 0x10..0x1F; drive rx_valid=1 with rx_data=0x77 and blk_ready=1 in the same cycle -> transfer occurs; byte_cnt=1; overflow=0. The next 15 bytes 0x78..0x86 give blk_data=128'h7778...86.
REQ-030 Send 7 bytes, assert rstn=0 for 1 cycle, then send 16 bytes 0xC0..0xCF -> all outputs at reset values after the reset edge; block = 0xC0..0xCF.
REQ-031 With RX_TIMEOUT_EN and TIMEOUT_CYCLES=50: send 3 bytes, idle 60 cycles -> one timeout pulse 50 cycles after the 3rd byte; byte_cnt=0. Without the macro -> timeout stays 0 and byte_cnt stays 3.
